// File: rtl/weight_loader_pkg.sv
// Shared types and default sizing for the weight loader slice.
// The optional checksum stage is built only when WEIGHT_LOADER_CHECKSUM_EN is defined.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int DEF_NUM_WEIGHT = 4;
    localparam int DEF_NUM_NEURON = 2;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 3;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream input plus neuron-memory write bus of the weight loader.
// Handshake: a word moves on a rising clk edge where s_valid && s_ready; s_data must be stable while s_valid is high.
interface weight_loader_if #(
    parameter int dataWidth = 16,
    parameter int addrWidth = 3,
    parameter int numNeuron = 2
);
    logic                 s_valid;
    logic [dataWidth-1:0] s_data;
    logic                 s_ready;
    logic [numNeuron-1:0] wen;
    logic [addrWidth-1:0] wadd;
    logic [dataWidth-1:0] win;

    modport master (output s_valid, s_data, input s_ready, wen, wadd, win);
    modport slave  (input s_valid, s_data, output s_ready, wen, wadd, win);
endinterface

// File: rtl/weight_loader_index_counter.sv
// Word/neuron index pair: word wraps at numWeight-1 and carries into the neuron index.
// last flags the final word of the final neuron.
module wl_index_counter
    import weight_loader_pkg::*;
#(
    parameter int numWeight = DEF_NUM_WEIGHT,
    parameter int numNeuron = DEF_NUM_NEURON,
    parameter int addrWidth = DEF_ADDR_WIDTH,
    localparam int NIW = idx_width(numNeuron)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [addrWidth-1:0] word_idx,
    output logic [NIW-1:0]       neuron_idx,
    output logic                 last
);
    logic word_last;
    logic neuron_last;

    assign word_last   = (word_idx == addrWidth'(numWeight - 1));
    assign neuron_last = (neuron_idx == NIW'(numNeuron - 1));
    assign last        = word_last && neuron_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx   <= '0;
            neuron_idx <= '0;
        end else if (clr) begin
            word_idx   <= '0;
            neuron_idx <= '0;
        end else if (inc) begin
            if (word_last) begin
                word_idx   <= '0;
                neuron_idx <= neuron_last ? '0 : neuron_idx + 1'b1;
            end else begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/weight_loader.sv
// Streams numNeuron x numWeight words into one-hot selected neuron memories.
// Define WEIGHT_LOADER_CHECKSUM_EN to add a trailing checksum word and the sticky err flag.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int numWeight = DEF_NUM_WEIGHT,
    parameter int numNeuron = DEF_NUM_NEURON,
    parameter int dataWidth = DEF_DATA_WIDTH,
    parameter int addrWidth = DEF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    weight_loader_if.slave   s,
    output logic             busy,
    output logic             done,
    output logic             err,
    output state_t           state_dbg
);
    localparam int NIW = idx_width(numNeuron);

    state_t               state, state_nxt;
    logic                 xfer;
    logic                 ld_xfer;
    logic                 cnt_clr;
    logic                 idle_start;
    logic [addrWidth-1:0] word_idx;
    logic [NIW-1:0]       neuron_idx;
    logic                 last;

    assign s.s_ready  = (state == ST_LOAD) || (state == ST_CHECK);
    assign xfer       = s.s_valid && s.s_ready;
    assign ld_xfer    = xfer && (state == ST_LOAD);
    assign idle_start = (state == ST_IDLE) && start;
    assign cnt_clr    = idle_start || (state == ST_FIN);
    assign busy       = (state != ST_IDLE);
    assign state_dbg  = state;

    wl_index_counter #(
        .numWeight(numWeight),
        .numNeuron(numNeuron),
        .addrWidth(addrWidth)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .inc       (ld_xfer),
        .word_idx  (word_idx),
        .neuron_idx(neuron_idx),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            ST_LOAD:  if (ld_xfer && last) state_nxt = ST_CHECK;
            ST_CHECK: if (xfer) state_nxt = ST_FIN;
`else
            ST_LOAD:  if (ld_xfer && last) state_nxt = ST_FIN;
            ST_CHECK: state_nxt = ST_IDLE;
`endif
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Write bus lags acceptance by one cycle; done follows the FIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.wen  <= '0;
            s.wadd <= '0;
            s.win  <= '0;
            done   <= 1'b0;
        end else begin
            s.wen <= ld_xfer ? (numNeuron'(1) << neuron_idx) : '0;
            if (ld_xfer) begin
                s.wadd <= word_idx;
                s.win  <= s.s_data;
            end
            done <= (state == ST_FIN);
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [dataWidth-1:0] sum;
    logic [dataWidth-1:0] ck_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            ck_word <= '0;
            err     <= 1'b0;
        end else begin
            if (idle_start) begin
                sum <= '0;
                err <= 1'b0;
            end else if (ld_xfer) begin
                sum <= sum + s.s_data;
            end
            if (xfer && (state == ST_CHECK)) ck_word <= s.s_data;
            if ((state == ST_FIN) && (sum != ck_word)) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter numWeight, default 4, weights per neuron memory.
REQ-002 SHALL have parameter numNeuron, default 2, neuron memories served.
REQ-003 SHALL have parameter dataWidth, default 16, weight word width.
REQ-004 SHALL have parameter addrWidth, default 3, weight address width (2^addrWidth >= numWeight).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle load request.
REQ-008 SHALL have port s_valid  input  1  stream word valid.
REQ-009 SHALL have port s_data  input  dataWidth  stream word.
REQ-010 SHALL have port s_ready  output  1  loader accepts word.
REQ-011 SHALL have port wen  output  numNeuron  one-hot memory write enable.
REQ-012 SHALL have port wadd  output  addrWidth  write address.
REQ-013 SHALL have port win  output  dataWidth  write data.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port err  output  1  sticky checksum error.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> (CHECK) -> FIN -> IDLE.
REQ-018 SHALL leave IDLE for LOAD on start=1; start in any other state ignored.
REQ-019 SHALL drive s_ready=1 only in LOAD and CHECK; transfer occurs when s_valid && s_ready.
REQ-020 SHALL, per LOAD transfer, register wen one-hot at current neuron index, wadd = word index, win = s_data, one cycle after acceptance (latency 1); wen=0 on cycles without transfer.
REQ-021 SHALL increment word index per transfer, wrapping numWeight-1 -> 0 while incrementing neuron index.
REQ-022 SHALL, after transfer of word numWeight-1 of neuron numNeuron-1, go to CHECK (macro defined) or FIN (macro undefined).
REQ-023 SHALL in FIN pulse done=1 for exactly one cycle, then return to IDLE with counters at 0.
REQ-024 SHALL hold busy=1 in every state except IDLE.
REQ-025 SHALL stall without side effects while s_valid=0 in LOAD/CHECK (no timeout).
REQ-026 SHALL clear err on start and set it only per REQ-032.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-load, asynchronously force IDLE, counters 0, s_ready=0, wen=0, wadd=0, win=0, busy=0, done=0, err=0.
REQ-028 SHALL resume only via new start after rst_n release; partially written memories are not restored.

Configuration
REQ-029 SHALL compile checksum support only when macro WEIGHT_LOADER_CHECKSUM_EN is defined.
REQ-030 SHALL, with macro, accumulate modulo-2^dataWidth sum of all accepted weights, cleared on start.
REQ-031 SHALL, with macro, accept one extra word in CHECK (no memory write) as expected checksum, then go to FIN.
REQ-032 SHALL, with macro, set err in FIN cycle if checksum mismatches; done still pulses.
REQ-033 SHALL, without macro, omit CHECK and accumulator and tie err=0.

Structure
REQ-034 SHALL place FSM state encoding and default width constants in shared package weight_loader_pkg.
REQ-035 SHALL implement word/neuron index logic as sub-module wl_index_counter (inc, wrap, last outputs).

Verification
REQ-036 SHALL cover: reset, start, 8 words 0x0001..0x0008 back-to-back -> wen=01 wadd 0..3 data 1..4, wen=10 wadd 0..3 data 5..8, done pulse 1 cycle after last write.
REQ-037 SHALL cover: s_valid toggling every other cycle -> identical writes, no wen on idle cycles, done after 8 transfers.
REQ-038 SHALL cover: start asserted during LOAD -> ignored, addresses continue unchanged.
REQ-039 SHALL cover: rst_n low after 3 words -> all outputs 0 immediately; new start writes neuron 0 address 0 first.
REQ-040 SHALL cover with WEIGHT_LOADER_CHECKSUM_EN: words 1..8 then 0x0024 -> err=0; then 0x0025 -> err=1, done pulses, no write of checksum word.
